// File: rtl/dc_remover_pkg.sv
// dc_remover_pkg
//   Shared types and helpers for the DC remover.
//   - dc_state_t : acquisition state (FILL, SETTLE, LOCKED)
//   - sat_sub    : unsigned a - b, saturated to the signed range of a given width
package dc_remover_pkg;

  typedef enum logic [1:0] {FILL, SETTLE, LOCKED} dc_state_t;

  // Container width for sat_sub; callers must use widths below this.
  localparam int SAT_MAX_W = 32;

  // Returns clip(a - b) into [-2^(w-1), 2^(w-1)-1], sign-extended to SAT_MAX_W.
  // Callers truncate the result to w bits.
  function automatic logic signed [SAT_MAX_W-1:0] sat_sub(
    input logic [SAT_MAX_W-1:0] a,
    input logic [SAT_MAX_W-1:0] b,
    input int                   w
  );
    logic signed [SAT_MAX_W:0] diff;
    logic signed [SAT_MAX_W:0] hi;
    logic signed [SAT_MAX_W:0] lo;
    diff = $signed({1'b0, a}) - $signed({1'b0, b});
    hi   = ((SAT_MAX_W+1)'(1) <<< (w - 1)) - (SAT_MAX_W+1)'(1);
    lo   = -((SAT_MAX_W+1)'(1) <<< (w - 1));
    if (diff > hi) begin
      diff = hi;
    end else if (diff < lo) begin
      diff = lo;
    end
    return diff[SAT_MAX_W-1:0];
  endfunction

endpackage

// File: rtl/dc_remover_window_averager.sv
// window_averager
//   Block-mean estimator over 2^AVG_SHIFT consecutive samples.
//   Ports:
//     adc_clk  in  sample clock
//     rst_n    in  asynchronous active-low reset (discards any partial window)
//     data_in  in  unsigned sample, accumulated every edge
//     mean     out truncated mean of the window; valid while win_done is high
//     win_done out high during the cycle whose edge consumes the last sample
module window_averager
  import dc_remover_pkg::*;
#(
  parameter int DATA_WIDTH = 12,
  parameter int AVG_SHIFT  = 10
) (
  input  logic                  adc_clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] mean,
  output logic                  win_done
);

  // 2^AVG_SHIFT samples of at most 2^DATA_WIDTH-1 each fit without overflow.
  localparam int ACC_W = DATA_WIDTH + AVG_SHIFT;

  logic [ACC_W-1:0]     acc_q;
  logic [ACC_W-1:0]     sum;
  logic [AVG_SHIFT-1:0] cnt_q;

  // The mean includes the sample being consumed on the window-end edge.
  assign sum      = acc_q + ACC_W'(data_in);
  assign win_done = &cnt_q;
  assign mean     = sum[ACC_W-1:AVG_SHIFT];

  always_ff @(posedge adc_clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
      cnt_q <= '0;
    end else begin
      acc_q <= win_done ? '0 : sum;
      cnt_q <= cnt_q + AVG_SHIFT'(1);
    end
  end

endmodule

// File: rtl/dc_remover.sv
// dc_remover
//   Removes the DC offset from offset-binary ADC samples. The DC level is the
//   block mean over 2^AVG_SHIFT samples; it is subtracted from each sample with
//   saturation. dc_ready reports that consecutive window means agree.
//   Optional feature macro: DC_REMOVER_HYST_EN (estimate update dead-band of
//   HYST_LSB; without it the estimate follows every window mean).
//   Ports:
//     adc_clk   in  sample clock, one sample per rising edge
//     rst_n     in  asynchronous active-low reset
//     data_in   in  unsigned offset-binary sample
//     data_out  out signed, DC-removed, saturated sample (1-cycle latency)
//     dc_level  out current unsigned DC estimate
//     dc_ready  out estimate locked
module dc_remover
  import dc_remover_pkg::*;
#(
  parameter int DATA_WIDTH     = 12,
  parameter int AVG_SHIFT      = 10,
  parameter int SETTLE_WINDOWS = 3,
  parameter int MEAN_TOL       = 2,
  parameter int HYST_LSB       = 4
) (
  input  logic                         adc_clk,
  input  logic                         rst_n,
  input  logic [DATA_WIDTH-1:0]        data_in,
  output logic signed [DATA_WIDTH-1:0] data_out,
  output logic [DATA_WIDTH-1:0]        dc_level,
  output logic                         dc_ready
);

  localparam logic [DATA_WIDTH-1:0] MID_SCALE = {1'b1, {(DATA_WIDTH-1){1'b0}}};
  localparam int                    CNT_W     = $clog2(SETTLE_WINDOWS + 1);
  localparam logic [CNT_W-1:0]      SETTLE_LAST = CNT_W'(SETTLE_WINDOWS - 1);
  localparam logic [DATA_WIDTH:0]   TOL_U     = (DATA_WIDTH+1)'(MEAN_TOL);
  localparam logic [DATA_WIDTH:0]   HYST_U    = (DATA_WIDTH+1)'(HYST_LSB);
`ifdef DC_REMOVER_HYST_EN
  localparam bit HYST_OFF = 1'b0;
`else
  localparam bit HYST_OFF = 1'b1;
`endif

  logic [DATA_WIDTH-1:0]        mean;
  logic                         win_done;
  logic [DATA_WIDTH-1:0]        prev_mean;
  logic signed [DATA_WIDTH:0]   delta;
  logic signed [DATA_WIDTH:0]   lvl_diff;
  logic [DATA_WIDTH:0]          abs_delta;
  logic [DATA_WIDTH:0]          abs_lvl_diff;
  logic                         agree;
  logic                         level_upd;
  dc_state_t                    state_q;
  dc_state_t                    state_d;
  logic [CNT_W-1:0]             cnt_q;
  logic [CNT_W-1:0]             cnt_d;

  window_averager #(
    .DATA_WIDTH (DATA_WIDTH),
    .AVG_SHIFT  (AVG_SHIFT)
  ) u_avg (
    .adc_clk  (adc_clk),
    .rst_n    (rst_n),
    .data_in  (data_in),
    .mean     (mean),
    .win_done (win_done)
  );

  // Window-to-window change drives lock; change versus the current estimate
  // drives the optional dead-band. |x| of a DATA_WIDTH+1 difference of two
  // unsigned DATA_WIDTH values never overflows.
  assign delta        = $signed({1'b0, mean}) - $signed({1'b0, prev_mean});
  assign lvl_diff     = $signed({1'b0, mean}) - $signed({1'b0, dc_level});
  assign abs_delta    = delta[DATA_WIDTH] ? -delta : delta;
  assign abs_lvl_diff = lvl_diff[DATA_WIDTH] ? -lvl_diff : lvl_diff;
  assign agree        = (abs_delta <= TOL_U);
  assign level_upd    = (state_q == FILL) || HYST_OFF || (abs_lvl_diff > HYST_U);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (win_done) begin
      case (state_q)
        FILL: begin
          state_d = SETTLE;
          cnt_d   = '0;
        end
        SETTLE: begin
          if (!agree) begin
            cnt_d = '0;
          end else if (cnt_q >= SETTLE_LAST) begin
            state_d = LOCKED;  // count holds: saturates instead of wrapping
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        LOCKED: begin
          if (!agree) begin
            state_d = SETTLE;
            cnt_d   = '0;
          end
        end
        default: begin
          state_d = FILL;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Stage p1: state, estimate and subtract/clip output registers.
  // The window-end edge still subtracts the old dc_level.
  always_ff @(posedge adc_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= FILL;
      cnt_q     <= '0;
      dc_ready  <= 1'b0;
      dc_level  <= MID_SCALE;
      prev_mean <= MID_SCALE;
      data_out  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      dc_ready <= (state_d == LOCKED);
      if (win_done) begin
        prev_mean <= mean;
        if (level_upd) begin
          dc_level <= mean;
        end
      end
      data_out <= DATA_WIDTH'(sat_sub(SAT_MAX_W'(data_in), SAT_MAX_W'(dc_level), DATA_WIDTH));
    end
  end

endmodule

// File: doc/dc_remover.md
# dc_remover

Removes the DC offset from raw offset-binary ADC samples and produces the signed, zero-centred stream that the zero-crossing frequency detector requires. The DC level is estimated as a block mean over a fixed power-of-two window and subtracted from every sample with saturation. `dc_ready` indicates that the estimate has settled; it is intended to gate the downstream detector's `rst_n`.

## Interface
- `DATA_WIDTH`, 12: sample width, for both input and output.
- `AVG_SHIFT`, 10: averaging window of 2^AVG_SHIFT samples.
- `SETTLE_WINDOWS`, 3: consecutive agreeing windows required before lock.
- `MEAN_TOL`, 2: maximum |Δmean| (LSB) between windows still counted as agreeing.
- `HYST_LSB`, 4: estimate update dead-band; used only with the `_EN` macro.

- `adc_clk`  in  1: sample clock; one sample per rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `data_in`  in  DATA_WIDTH: unsigned offset-binary ADC sample.
- `data_out`  out  DATA_WIDTH, signed: DC-removed, saturated sample.
- `dc_level`  out  DATA_WIDTH: current DC estimate, unsigned.
- `dc_ready`  out  1: estimate locked.

## Operation
- Accumulator is DATA_WIDTH+AVG_SHIFT bits wide and cannot overflow. Window counter is AVG_SHIFT bits and wraps naturally.
- Each edge adds `data_in` to the accumulator. On the edge that consumes the last sample of a window:
  - compute `mean = (acc + data_in) >> AVG_SHIFT` (truncating);
  - clear the accumulator to 0;
  - compute `delta = mean − prev_mean` (signed, DATA_WIDTH+1 bits);
  - set `prev_mean <= mean`.
- `dc_level` takes `mean` at every window end (see Configuration).
- State machine (state, settle count):
  - FILL: initial state. At the first window end go to SETTLE with count 0. `prev_mean` is loaded; `delta` is ignored.
  - SETTLE: at each window end, if |delta| ≤ MEAN_TOL then count+1, else count←0. When count+1 reaches SETTLE_WINDOWS, go to LOCKED.
  - LOCKED: at a window end with |delta| > MEAN_TOL, go to SETTLE with count 0.
- `dc_ready` = (state == LOCKED), registered and changing on the same edge as the state.
- Output: `data_out = clip(data_in − dc_level)`.
  - Subtraction is DATA_WIDTH+1-bit signed.
  - Result is clipped to [−2^(DATA_WIDTH−1), 2^(DATA_WIDTH−1)−1].
- Subtraction runs in every state. During FILL, `dc_level` = mid-scale, so the block acts as an offset-binary to two's-complement converter.
- Reset values:
  - `data_out` = 0;
  - `dc_level` = 2^(DATA_WIDTH−1);
  - `dc_ready` = 0;
  - state FILL, accumulator 0, counter 0, settle count 0, `prev_mean` mid-scale.

## Timing
- `data_out` latency is 1 cycle: the value after edge n+1 uses `data_in` and `dc_level` as sampled at edge n.
- A window-end edge still subtracts the old `dc_level`. The new estimate applies from the next sample.
- Minimum time to `dc_ready` = (1+SETTLE_WINDOWS)·2^AVG_SHIFT cycles after reset release.
- Loss of lock is reported within one window of the offset change. `dc_ready` falls at that window end.
- Reset mid-window: the partial sum is discarded and acquisition restarts in FILL. No partial window ever produces a mean.
- Settle count saturates and cannot wrap.

## Configuration
- Macro: `DC_REMOVER_HYST_EN`.
- Defined: at a window end, `dc_level` is replaced only if |mean − dc_level| > HYST_LSB; otherwise it is held. Window end in FILL always loads unconditionally.
- Undefined: `dc_level` takes `mean` at every window end, and HYST_LSB is unused.
- Lock logic always uses the raw `delta`, independent of the macro.

## Structure
- Package `dc_remover_pkg` holds:
  - `dc_state_t` enum {FILL, SETTLE, LOCKED};
  - a saturating-subtract function parameterised on width.
- Sub-module `window_averager` holds the accumulator and window counter. It outputs `mean` and a one-cycle `win_done` pulse.
- The top level holds the state machine, the estimate register and the output subtract/clip.

## Test plan
All scenarios use DATA_WIDTH=12, AVG_SHIFT=4, SETTLE_WINDOWS=2, MEAN_TOL=1, HYST_LSB=4.
- Reset state: hold `rst_n`=0 → `data_out`=0, `dc_level`=2048, `dc_ready`=0. With `rst_n`=1 and `data_in`=2048 → `data_out`=0.
- Constant input 3000:
  - `dc_level`=3000 after edge 16;
  - `data_out`=952 through sample 16 and 0 from sample 17;
  - `dc_ready` rises on edge 48.
- Clipping:
  - in FILL, input 0 → −2048 and input 4095 → 2047;
  - locked at 100, input 4095 → 2047 (saturated, not 3995).
- Square wave 1000/3000 toggling every cycle → locks at `dc_level`=2000. `data_out` alternates −1000/+1000.
- Step 3000→1000 mid-window while locked:
  - `dc_ready` falls at that window end;
  - `dc_level`=1000 from the first full window after the step;
  - `dc_ready` re-rises at the end of the second consecutive window with |delta| ≤ 1.
- Hysteresis: locked at 2000, input moves to 2003 → `dc_level` stays 2000 with `DC_REMOVER_HYST_EN`, becomes 2003 without it. A reset pulse mid-window returns to FILL with `dc_ready`=0 in both builds.
